// File: rtl/mips_shift_pkg.sv
// mips_shift_pkg
//   Shared definitions for the pipelined MIPS-style shifter:
//   - shift_op_e   : operation encoding carried down the pipe
//   - count_w      : width of the shift-amount port for a given datapath width
//   - stage_levels : number of binary mux levels assigned to a register stage
//   - stage_first  : index of the first mux level handled by a register stage
package mips_shift_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROR = 3'd3,
    OP_ROL = 3'd4
  } shift_op_e;

  // Shift amount spans 0..2*width-1, one bit wider than a level index.
  function automatic int count_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // Levels are spread evenly; the first (levels % stages) stages take one extra.
  function automatic int stage_levels(input int levels, input int stages, input int k);
    return (levels / stages) + ((k < (levels % stages)) ? 1 : 0);
  endfunction

  function automatic int stage_first(input int levels, input int stages, input int k);
    return (k * (levels / stages)) + ((k < (levels % stages)) ? k : (levels % stages));
  endfunction

endpackage

// File: rtl/mips_shift_stage.sv
// mips_shift_stage
//   One register slice of the shifter. Applies N_LEVELS binary mux levels,
//   starting at level FIRST_LEVEL, to the incoming extended word and registers
//   the result together with count, op, tag and a valid bit.
//
//   The extended word is WIDTH+1 bits so the last shifted-out bit falls into
//   the spare position naturally:
//     SLL             : {last_bit, data}
//     SRL / SRA       : {data, last_bit}
//     rotates/reserved: {1'b0, data}
//
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     flush        clears the valid bit at the next edge
//     load         slice captures its input this cycle (empty or advancing)
//     in_*         upstream slice / input pre-processing
//     out_*        registered slice contents
module mips_shift_stage
  import mips_shift_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 4,
  parameter int FIRST_LEVEL = 0,
  parameter int N_LEVELS    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       load,
  input  logic                       in_valid,
  input  logic [WIDTH:0]             in_ext,
  input  logic [$clog2(WIDTH)-1:0]   in_count,
  input  logic [2:0]                 in_op,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  output logic [WIDTH:0]             out_ext,
  output logic [$clog2(WIDTH)-1:0]   out_count,
  output logic [2:0]                 out_op,
  output logic [TAG_W-1:0]           out_tag
);

  logic [WIDTH:0]           ext_n;
  logic [WIDTH-1:0]         word;
  logic [$clog2(WIDTH)-1:0] sel;
  int unsigned              amt;

  always_comb begin
    ext_n = in_ext;
    word  = '0;
    sel   = '0;
    amt   = 0;
    for (int unsigned i = 0; i < N_LEVELS; i++) begin
      amt = 32'd1 << (FIRST_LEVEL + i);
      sel = in_count >> (FIRST_LEVEL + i);
      word = ext_n[WIDTH-1:0];
      if (sel[0]) begin
        case (shift_op_e'(in_op))
          OP_SLL:  ext_n = ext_n << amt;
          OP_SRL:  ext_n = ext_n >> amt;
          OP_SRA:  ext_n = $signed(ext_n) >>> amt;
          OP_ROR:  ext_n = {1'b0, (word >> amt) | (word << (WIDTH - amt))};
          OP_ROL:  ext_n = {1'b0, (word << amt) | (word >> (WIDTH - amt))};
          default: ext_n = in_ext;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ext   <= '0;
      out_count <= '0;
      out_op    <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      out_ext   <= ext_n;
      out_count <= in_count;
      out_op    <= in_op;
      out_tag   <= in_tag;
    end
  end

endmodule

// File: rtl/mips_pipe_shifter.sv
// mips_pipe_shifter
//   Pipelined barrel shifter (SLL/SRL/SRA/ROR/ROL) with valid/ready handshakes
//   on both sides, a sideband tag and a last-shifted-out bit.
//
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     in_valid/in_ready   input handshake; in_ready is combinational from out_ready
//     in_data, in_count   operand and shift amount (0..2*WIDTH-1)
//     in_op, in_tag       operation code (5..7 pass through) and sideband tag
//     flush               drops every in-flight operation at the next edge
//     out_valid/out_ready output handshake
//     out_data, out_tag   result and its tag
//     out_last_bit        last bit shifted out (0 for rotates and count 0)
module mips_pipe_shifter
  import mips_shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [count_w(WIDTH)-1:0] in_count,
  input  logic [2:0]                in_op,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_last_bit
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int CW     = count_w(WIDTH);
  localparam int LAST   = STAGES - 1;

  logic              sat;
  logic              exact;
  logic              accept;
  logic [WIDTH:0]    ext_d;
  logic [LEVELS-1:0] cnt_d;
  logic              free;

  logic              v_q   [STAGES];
  logic [WIDTH:0]    ext_q [STAGES];
  logic [LEVELS-1:0] cnt_q [STAGES];
  logic [2:0]        op_q  [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic              adv   [STAGES];
  logic              load  [STAGES];

  // Counts >= WIDTH can't be expressed by the mux levels, so shifts are
  // resolved here into their final fill value and last bit with a zero
  // residual count; the stages then pass them through untouched.
  always_comb begin
    sat   = in_count[CW-1];
    exact = (in_count == CW'(WIDTH));
    cnt_d = in_count[LEVELS-1:0];
    ext_d = {1'b0, in_data};
    case (shift_op_e'(in_op))
      OP_SLL: begin
        if (sat) begin
          ext_d = {exact & in_data[0], {WIDTH{1'b0}}};
          cnt_d = '0;
        end
      end
      OP_SRL: begin
        if (sat) begin
          ext_d = {{WIDTH{1'b0}}, exact & in_data[WIDTH-1]};
          cnt_d = '0;
        end else begin
          ext_d = {in_data, 1'b0};
        end
      end
      OP_SRA: begin
        if (sat) begin
          ext_d = {(WIDTH+1){in_data[WIDTH-1]}};
          cnt_d = '0;
        end else begin
          ext_d = {in_data, 1'b0};
        end
      end
      OP_ROR, OP_ROL: ;
      default: cnt_d = '0;
    endcase
  end

  // Ready ripples back from out_ready: a slice can load when it is empty or
  // its content moves on this cycle.
  always_comb begin
    free = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[i]  = 1'b0;
      load[i] = 1'b0;
    end
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[LAST-i]  = v_q[LAST-i] && free;
      load[LAST-i] = !v_q[LAST-i] || adv[LAST-i];
      free         = load[LAST-i];
    end
  end

  assign in_ready = rst_n && !flush && load[0];
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              up_valid;
    logic [WIDTH:0]    up_ext;
    logic [LEVELS-1:0] up_cnt;
    logic [2:0]        up_op;
    logic [TAG_W-1:0]  up_tag;

    if (k == 0) begin : g_head
      assign up_valid = accept;
      assign up_ext   = ext_d;
      assign up_cnt   = cnt_d;
      assign up_op    = in_op;
      assign up_tag   = in_tag;
    end else begin : g_body
      assign up_valid = adv[k-1];
      assign up_ext   = ext_q[k-1];
      assign up_cnt   = cnt_q[k-1];
      assign up_op    = op_q[k-1];
      assign up_tag   = tag_q[k-1];
    end

    mips_shift_stage #(
      .WIDTH      (WIDTH),
      .TAG_W      (TAG_W),
      .FIRST_LEVEL(stage_first(LEVELS, STAGES, k)),
      .N_LEVELS   (stage_levels(LEVELS, STAGES, k))
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .load     (load[k]),
      .in_valid (up_valid),
      .in_ext   (up_ext),
      .in_count (up_cnt),
      .in_op    (up_op),
      .in_tag   (up_tag),
      .out_valid(v_q[k]),
      .out_ext  (ext_q[k]),
      .out_count(cnt_q[k]),
      .out_op   (op_q[k]),
      .out_tag  (tag_q[k])
    );
  end

  assign out_valid = v_q[LAST];
  assign out_tag   = tag_q[LAST];

  always_comb begin
    out_data     = ext_q[LAST][WIDTH-1:0];
    out_last_bit = 1'b0;
    case (shift_op_e'(op_q[LAST]))
      OP_SLL: out_last_bit = ext_q[LAST][WIDTH];
      OP_SRL, OP_SRA: begin
        out_data     = ext_q[LAST][WIDTH:1];
        out_last_bit = ext_q[LAST][0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_pipe_shifter.sv
// tb_mips_pipe_shifter
//   Scoreboard bench: stimulus pushes expected results on acceptance, a
//   negedge monitor pops and compares on every output handshake.
module tb_mips_pipe_shifter;

  localparam int W  = 32;
  localparam int ST = 2;
  localparam int TW = 4;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_count;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_last_bit;

  always #5 clk = ~clk;

  mips_pipe_shifter #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_count(in_count), .in_op(in_op), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_last_bit(out_last_bit)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          lb;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   last_out_cyc = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h tag=%0h required=no output", out_data, out_tag);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_tag", out_tag, mon_e.tag);
        chk("out_last_bit", out_last_bit, mon_e.lb);
        if (mon_e.lat) chk("latency", cyc - mon_e.acc, ST);
        n_out++;
        last_out_cyc = cyc;
      end
    end
  end

  // Independent reference: {last_bit, result}.
  function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] d, input int c);
    logic [W-1:0] r;
    logic         lb;
    int           m;
    r  = d;
    lb = 1'b0;
    m  = c % W;
    case (op)
      3'd0: begin
        if (c > 0 && c < W) begin r = d << c; lb = d[W-c]; end
        else if (c == W) begin r = '0; lb = d[0]; end
        else if (c > W) r = '0;
      end
      3'd1: begin
        if (c > 0 && c < W) begin r = d >> c; lb = d[c-1]; end
        else if (c == W) begin r = '0; lb = d[W-1]; end
        else if (c > W) r = '0;
      end
      3'd2: begin
        if (c > 0 && c < W) begin r = $signed(d) >>> c; lb = d[c-1]; end
        else if (c >= W) begin r = {W{d[W-1]}}; lb = d[W-1]; end
      end
      3'd3: r = (m == 0) ? d : ((d >> m) | (d << (W - m)));
      3'd4: r = (m == 0) ? d : ((d << m) | (d >> (W - m)));
      default: ;
    endcase
    return {lb, r};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] d, input int c,
                      input logic [TW-1:0] t, input logic [W-1:0] ed, input logic elb,
                      input bit lat);
    exp_t e;
    bit   done = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_count = CW'(c);
    in_tag   = t;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = ed; e.tag = t; e.lb = elb; e.acc = cyc; e.lat = lat;
        sbq.push_back(e);
        last_acc = cyc;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not accepted required=accepted tag=%0h", t);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [W:0]    r;
    logic [2:0]    op;
    logic [W-1:0]  d;
    int            c;
    int            first_acc;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_data = '0; in_count = '0; in_op = '0; in_tag = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_last_bit", out_last_bit, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors, streamed back to back with out_ready high
    send(3'd2, 32'h8000_0000,  4, 4'h1, 32'hF800_0000, 1'b0, 1);
    send(3'd2, 32'h8000_0000, 40, 4'h2, 32'hFFFF_FFFF, 1'b1, 1);
    send(3'd3, 32'h0000_0001, 33, 4'h3, 32'h8000_0000, 1'b0, 1);
    send(3'd4, 32'h8000_0001,  4, 4'h4, 32'h0000_0018, 1'b0, 1);
    send(3'd0, 32'h0000_0003, 31, 4'h5, 32'h8000_0000, 1'b1, 1);
    send(3'd0, 32'h0000_0003, 32, 4'h6, 32'h0000_0000, 1'b1, 1);
    send(3'd1, 32'h0000_0018,  4, 4'h7, 32'h0000_0001, 1'b1, 1);
    send(3'd1, 32'h8000_0000, 32, 4'h8, 32'h0000_0000, 1'b1, 1);
    send(3'd1, 32'hFFFF_FFFF, 33, 4'h9, 32'h0000_0000, 1'b0, 1);
    send(3'd0, 32'hFFFF_FFFF, 40, 4'hA, 32'h0000_0000, 1'b0, 1);
    send(3'd0, 32'h1234_5678,  0, 4'hB, 32'h1234_5678, 1'b0, 1);
    send(3'd2, 32'h7FFF_FFF0, 63, 4'hC, 32'h0000_0000, 1'b0, 1);
    send(3'd2, 32'h8000_0010,  5, 4'hD, 32'hFC00_0000, 1'b1, 1);
    send(3'd5, 32'hDEAD_BEEF,  7, 4'hE, 32'hDEAD_BEEF, 1'b0, 1);
    send(3'd7, 32'h0000_0001, 63, 4'hF, 32'h0000_0001, 1'b0, 1);
    send(3'd4, 32'h0000_00A5,  0, 4'h0, 32'h0000_00A5, 1'b0, 1);
    send(3'd3, 32'h0000_000F,  4, 4'h1, 32'hF000_0000, 1'b0, 1);
    send(3'd4, 32'h1234_5678, 36, 4'h2, 32'h2345_6781, 1'b0, 1);
    send(3'd0, 32'h0000_0001,  1, 4'h3, 32'h0000_0002, 1'b0, 1);
    in_valid = 1'b0;
    drain();

    // Backpressure: two ops fill the pipe, the third is refused
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0001, 4, 4'h1, 32'h0000_0010, 1'b0, 0);
    send(3'd1, 32'h0000_0100, 8, 4'h2, 32'h0000_0001, 1'b0, 0);
    in_valid = 1'b1; in_op = 3'd3; in_data = 32'h0000_0002; in_count = 6'd1; in_tag = 4'h3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 32'h0000_0010);
      chk("bp_hold_tag", out_tag, 4'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd3, 32'h0000_0002, 1, 4'h3, 32'h0000_0001, 1'b0, 0);
    send(3'd2, 32'hF000_0000, 2, 4'h4, 32'hFC00_0000, 1'b0, 0);
    in_valid = 1'b0;
    drain();

    // Flush with two ops in flight; flush also blocks acceptance
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0001, 1, 4'h5, 32'h0000_0002, 1'b0, 0);
    send(3'd0, 32'h0000_0001, 2, 4'h6, 32'h0000_0004, 1'b0, 0);
    in_valid = 1'b1; in_op = 3'd0; in_data = 32'h0000_0001; in_count = 6'd3; in_tag = 4'h7;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd1, 32'h0000_00F0, 4, 4'h8, 32'h0000_000F, 1'b0, 1);
    in_valid = 1'b0;
    drain();

    // Reset mid-operation: in-flight ops must never appear
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0001, 5, 4'h9, 32'h0000_0020, 1'b0, 0);
    send(3'd0, 32'h0000_0001, 6, 4'hA, 32'h0000_0040, 1'b0, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbq.delete();
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    // Random back-to-back streaming against the reference model
    n_out = 0;
    first_acc = 0;
    for (int i = 0; i < 100; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = $urandom;
      c  = $urandom_range(0, 63);
      r  = model(op, d, c);
      send(op, d, c, TW'(i), r[W-1:0], r[W], 1);
      if (i == 0) first_acc = last_acc;
    end
    in_valid = 1'b0;
    drain();
    chk("stream_outputs", n_out, 100);
    chk("stream_span", last_out_cyc - first_acc, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_pipe_shifter.md
MIPS_PIPE_SHIFTER -- requirements
Module: mips_pipe_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width; power of two, 8..64.
REQ-002 SHALL have parameter STAGES, default 2: register stages, 1..log2(WIDTH).
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1: operation offered.
REQ-007 SHALL have port in_ready, output, 1: operation accepted when in_valid && in_ready at an edge.
REQ-008 SHALL have port in_data, input, WIDTH: operand.
REQ-009 SHALL have port in_count, input, log2(WIDTH)+1: shift amount, 0..2*WIDTH-1.
REQ-010 SHALL have port in_op, input, 3: operation code: SLL=0, SRL=1, SRA=2, ROR=3, ROL=4; codes 5..7 are reserved.
REQ-011 SHALL have port in_tag, input, TAG_W: sideband tag, passed through unmodified.
REQ-012 SHALL have port flush, input, 1: discard all in-flight operations.
REQ-013 SHALL have port out_valid, output, 1: result present.
REQ-014 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready at an edge.
REQ-015 SHALL have port out_data, output, WIDTH: result.
REQ-016 SHALL have port out_tag, output, TAG_W: tag of the result.
REQ-017 SHALL have port out_last_bit, output, 1: last bit shifted out; 0 for rotates and for count=0.

Function
REQ-018 SHALL compute SLL and SRL with zero fill, and SRA with fill by in_data[WIDTH-1].
REQ-019 SHALL saturate shifts when in_count >= WIDTH: SLL and SRL give 0; SRA gives WIDTH copies of the sign bit.
REQ-020 SHALL use in_count modulo WIDTH for ROR and ROL.
REQ-021 SHALL pass in_data through unchanged, with out_last_bit=0, for reserved op codes.
REQ-022 SHALL compute out_last_bit for SLL as bit WIDTH-count and for SRL/SRA as bit count-1, both when 1 <= count <= WIDTH.
REQ-023 SHALL, for SLL/SRL with count > WIDTH, give out_last_bit=0; for SRA with count > WIDTH, give out_last_bit = sign bit.
REQ-024 SHALL split the log2(WIDTH) binary mux levels as evenly as possible across STAGES, with earlier stages taking the extra levels.
REQ-025 SHALL register each stage, carrying data, residual count, op, tag, last_bit and a valid bit.
REQ-026 SHALL present an accepted operation on the outputs exactly STAGES cycles after acceptance when out_ready is held high.
REQ-027 SHALL sustain one operation per cycle with no bubbles under continuous in_valid and out_ready.
REQ-028 SHALL advance stage k when it holds valid data and stage k+1 is empty or advancing in the same cycle; the last stage advances on out_ready.
REQ-029 SHALL drive in_ready = !flush && (stage 0 empty || stage 0 advancing), so in_ready is combinational from out_ready.
REQ-030 SHALL, while out_valid && !out_ready, hold out_data, out_tag and out_last_bit stable.
REQ-031 SHALL never drop, duplicate or reorder operations.
REQ-032 SHALL, on flush, clear all valid bits at the next edge and accept no input in that cycle; flush has priority over acceptance.

Reset
REQ-033 SHALL, while rst_n=0 at an edge, clear all valid bits.
REQ-034 SHALL reset out_valid=0, out_data=0, out_tag=0, out_last_bit=0 and in_ready=0.
REQ-035 SHALL drive in_ready=1 from the first cycle after reset is released.
REQ-036 SHALL discard in-flight operations on reset mid-operation; no result from them appears afterwards.

Structure
REQ-037 SHALL place the op-code enum (shift_op_e) and the count-width function in package mips_shift_pkg.
REQ-038 SHALL implement each register slice as sub-module mips_shift_stage, parameterised by its first mux level and level count, and instantiate it STAGES times.

Verification (WIDTH=32, STAGES=2)
REQ-039 SHALL check SRA of 0x80000000 by 4 -> 0xF8000000 with last_bit=0, and SRA by 40 -> 0xFFFFFFFF with last_bit=1.
REQ-040 SHALL check ROR of 0x00000001 by 33 -> 0x80000000, and ROL of 0x80000001 by 4 -> 0x00000018.
REQ-041 SHALL check SLL of 0x00000003 by 31 -> 0x80000000 with last_bit=1, and SLL by 32 -> 0x00000000 with last_bit=1.
REQ-042 SHALL check backpressure: with out_ready=0, 4 ops offered -> in_ready falls after 2 accepted; release -> all 4 emerge in order with correct tags.
REQ-043 SHALL check flush with 2 ops in flight -> out_valid=0 next cycle, and the next op emerges 2 cycles after acceptance.
REQ-044 SHALL check back-to-back streaming of 100 random ops against a reference model -> zero mismatches and 100 outputs in 101 cycles.
